// File: rtl/fp_add_pkg.sv
// Shared types and constants for the single-precision add/sub sequencer.
package fp_add_pkg;

  localparam int unsigned MANT_W         = 24;
  localparam int unsigned GUARD_BITS_DEF = 2;

  localparam logic [7:0]  EXP_BIAS = 8'd127;
  localparam logic [7:0]  EXP_MAX  = 8'd255;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF  = 32'h7F80_0000;

  function automatic int unsigned ext_width(input int unsigned guard_bits);
    return MANT_W + guard_bits;
  endfunction

  localparam int unsigned EXT_W_DEF = ext_width(GUARD_BITS_DEF);

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } state_t;

endpackage

// File: rtl/fp_add_sequencer_align.sv
// Combinational exponent compare and right-shift alignment of two unpacked operands.
module fp_align_stage
  import fp_add_pkg::*;
#(
  parameter int unsigned EXT_W = EXT_W_DEF
) (
  input  logic [7:0]        exp_a,
  input  logic [MANT_W-1:0] man_a,
  input  logic [7:0]        exp_b,
  input  logic [MANT_W-1:0] man_b,
  output logic [7:0]        exp_c,
  output logic [EXT_W-1:0]  ext_a,
  output logic [EXT_W-1:0]  ext_b,
  output logic              a_larger
);

  localparam int unsigned GUARD       = EXT_W - MANT_W;
  localparam logic [7:0]  SHIFT_LIMIT = 8'(EXT_W);

  logic [7:0]       diff;
  logic [EXT_W-1:0] full_a, full_b;

  always_comb begin
    a_larger = (exp_a >= exp_b);
    full_a   = EXT_W'(man_a) << GUARD;
    full_b   = EXT_W'(man_b) << GUARD;
    exp_c    = a_larger ? exp_a : exp_b;
    diff     = a_larger ? (exp_a - exp_b) : (exp_b - exp_a);
    ext_a    = full_a;
    ext_b    = full_b;
    if (diff > SHIFT_LIMIT) begin
      if (a_larger) ext_b = '0;
      else          ext_a = '0;
    end else if (a_larger) begin
      ext_b = full_b >> diff;
    end else begin
      ext_a = full_a >> diff;
    end
  end

endmodule

// File: rtl/fp_add_sequencer.sv
// Multi-cycle IEEE-754 single add/sub: accept, align, signed-magnitude add,
// one-bit-per-cycle normalise; valid/ready handshakes on both sides.
module fp_add_sequencer
  import fp_add_pkg::*;
#(
  parameter int unsigned GUARD_BITS = GUARD_BITS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        op_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        flag_ovf,
  output logic        flag_unf,
  output logic        flag_nan
);

  localparam int unsigned EXT_W = ext_width(GUARD_BITS);

  state_t state, state_next;

  logic [31:0]      a_q, b_q;
  logic [7:0]       exp_q;
  logic [EXT_W-1:0] big_q, small_q, mant_q;
  logic             sign_big_q, sign_small_q, sign_q;

  logic [7:0]        exp_a, exp_b, exp_c;
  logic [MANT_W-1:0] man_a, man_b;
  logic [EXT_W-1:0]  ext_a, ext_b;
  logic              a_larger, special;

  logic [EXT_W:0]   sum;
  logic             sum_sign, carry, add_zero, add_ovf;
  logic [EXT_W-1:0] add_mant, norm_mant;
  logic [8:0]       add_exp;
  logic [7:0]       norm_exp;
  logic             norm_unf;

  always_comb begin : unpack
    exp_a   = a_q[30:23];
    exp_b   = b_q[30:23];
    man_a   = (exp_a == '0) ? '0 : {1'b1, a_q[22:0]};
    man_b   = (exp_b == '0) ? '0 : {1'b1, b_q[22:0]};
    special = (exp_a == EXP_MAX) || (exp_b == EXP_MAX);
  end

  fp_align_stage #(
    .EXT_W (EXT_W)
  ) u_align (
    .exp_a    (exp_a),
    .man_a    (man_a),
    .exp_b    (exp_b),
    .man_b    (man_b),
    .exp_c    (exp_c),
    .ext_a    (ext_a),
    .ext_b    (ext_b),
    .a_larger (a_larger)
  );

  // Equal exponents can still leave the "small" operand with the larger magnitude.
  always_comb begin : arith
    sum_sign = sign_big_q;
    if (sign_big_q == sign_small_q) begin
      sum = {1'b0, big_q} + {1'b0, small_q};
    end else if (big_q >= small_q) begin
      sum = {1'b0, big_q - small_q};
    end else begin
      sum      = {1'b0, small_q - big_q};
      sum_sign = sign_small_q;
    end
    carry     = sum[EXT_W];
    add_mant  = carry ? sum[EXT_W:1] : sum[EXT_W-1:0];
    add_exp   = {1'b0, exp_q} + {8'b0, carry};
    add_zero  = (sum == '0);
    add_ovf   = carry && (add_exp[7:0] == EXP_MAX);
    norm_mant = mant_q << 1;
    norm_exp  = exp_q - 8'd1;
    norm_unf  = (norm_exp == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // An already-normalised sum packs straight from ADD, so NORM runs only for k > 0.
  always_comb begin : next_state
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = ALIGN;
      ALIGN:   state_next = special ? DONE : ADD;
      ADD:     state_next = (add_zero || add_ovf || add_mant[EXT_W-1]) ? DONE : NORM;
      NORM:    if (norm_unf || norm_mant[EXT_W-1]) state_next = DONE;
      DONE:    if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin : outputs
    in_ready = (state == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin : datapath
    if (!rst_n) begin
      a_q          <= '0;
      b_q          <= '0;
      exp_q        <= '0;
      big_q        <= '0;
      small_q      <= '0;
      mant_q       <= '0;
      sign_big_q   <= 1'b0;
      sign_small_q <= 1'b0;
      sign_q       <= 1'b0;
      result       <= '0;
      flag_ovf     <= 1'b0;
      flag_unf     <= 1'b0;
      flag_nan     <= 1'b0;
      out_valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q      <= op_a;
          b_q      <= {op_b[31] ^ op_sub, op_b[30:0]};
          flag_ovf <= 1'b0;
          flag_unf <= 1'b0;
          flag_nan <= 1'b0;
        end
        ALIGN: if (special) begin
          result   <= QNAN;
          flag_nan <= 1'b1;
        end else begin
          exp_q        <= exp_c;
          big_q        <= a_larger ? ext_a : ext_b;
          small_q      <= a_larger ? ext_b : ext_a;
          sign_big_q   <= a_larger ? a_q[31] : b_q[31];
          sign_small_q <= a_larger ? b_q[31] : a_q[31];
        end
        ADD: if (add_zero) begin
          result <= '0;
        end else if (add_ovf) begin
          result   <= {sum_sign, POS_INF[30:0]};
          flag_ovf <= 1'b1;
        end else begin
          sign_q <= sum_sign;
          exp_q  <= add_exp[7:0];
          mant_q <= add_mant;
          if (add_mant[EXT_W-1])
            result <= {sum_sign, add_exp[7:0], add_mant[EXT_W-2:GUARD_BITS]};
        end
        NORM: if (norm_unf) begin
          result   <= {sign_q, 31'b0};
          flag_unf <= 1'b1;
        end else begin
          exp_q  <= norm_exp;
          mant_q <= norm_mant;
          if (norm_mant[EXT_W-1])
            result <= {sign_q, norm_exp, norm_mant[EXT_W-2:GUARD_BITS]};
        end
        default: ;
      endcase
      out_valid <= (state == DONE) && !(out_valid && out_ready);
    end
  end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed bench for fp_add_sequencer: literal vectors plus an arithmetic reference model
// checked against the outputs on every cycle.
module tb_fp_add_sequencer;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        nan;
    logic [7:0]  lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a, op_b;
  logic        op_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        flag_ovf, flag_unf, flag_nan;

  int tests = 0;
  int fails = 0;

  fp_add_sequencer #(.GUARD_BITS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_ovf  (flag_ovf),
    .flag_unf  (flag_unf),
    .flag_nan  (flag_nan)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Value-level model: scaled integers with 2 guard bits, a signed sum, then a leading-one search.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    exp_t   r;
    int     ea, eb, e, d, p, k;
    longint ma, mb, s, mag;
    logic   sa, sb, sgn;
    r  = '0;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    sa = a[31];
    sb = b[31] ^ sub;
    if (ea == 255 || eb == 255) begin
      r.res = 32'h7FC00000; r.nan = 1'b1; r.lat = 8'd2;
      return r;
    end
    ma = (ea == 0) ? 0 : longint'({1'b1, a[22:0]}) * 4;
    mb = (eb == 0) ? 0 : longint'({1'b1, b[22:0]}) * 4;
    if (ea >= eb) begin
      e = ea; d = ea - eb; mb = (d > 26) ? 0 : (mb >> d);
    end else begin
      e = eb; d = eb - ea; ma = (d > 26) ? 0 : (ma >> d);
    end
    s   = (sa ? -ma : ma) + (sb ? -mb : mb);
    sgn = (s < 0);
    mag = sgn ? -s : s;
    r.lat = 8'd3;
    if (mag == 0) return r;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    if (p == 26) begin
      mag = mag >> 1;
      e++;
      if (e == 255) begin
        r.res = {sgn, 31'h7F800000}; r.ovf = 1'b1;
        return r;
      end
      k = 0;
    end else begin
      k = 25 - p;
    end
    if (k > 0 && e <= k) begin
      r.res = {sgn, 31'b0}; r.unf = 1'b1; r.lat = 8'(3 + e);
      return r;
    end
    mag   = mag << k;
    e     = e - k;
    r.res = {sgn, 8'(e), 23'((mag >> 2) & 64'h7FFFFF)};
    r.lat = 8'(3 + k);
    return r;
  endfunction

  // Cycle monitor: out_valid must stay low for exactly the model latency, then hold the model result.
  int   nidx = 0;
  int   due = 0;
  bit   pending = 1'b0;
  exp_t mexp;

  always @(negedge clk) begin
    nidx++;
    if (!rst_n) begin
      pending = 1'b0;
      check("mon reset outputs", {out_valid, in_ready, result, flag_ovf, flag_unf, flag_nan},
            {1'b0, 1'b1, 32'h0, 3'b000});
    end else begin
      if (pending) begin
        if (nidx < due) begin
          check("mon busy", {out_valid, in_ready}, 2'b00);
        end else begin
          check("mon result", {out_valid, in_ready, result, flag_ovf, flag_unf, flag_nan},
                {1'b1, 1'b0, mexp.res, mexp.ovf, mexp.unf, mexp.nan});
          if (out_ready) pending = 1'b0;
        end
      end else begin
        check("mon idle", {out_valid, in_ready}, 2'b01);
      end
      if (!pending && in_valid && in_ready) begin
        mexp    = model(op_a, op_b, op_sub);
        pending = 1'b1;
        due     = nidx + 1 + int'(mexp.lat);
      end
    end
  end

  task automatic wait_ready(input string name);
    for (int j = 0; j < 60 && !in_ready; j++) begin
      @(posedge clk); #1;
    end
    check({name, " ready"}, in_ready, 1);
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [31:0] want, input logic [2:0] wflags,
                        input int wlat);
    exp_t m;
    int   lat;
    m = model(a, b, sub);
    check({name, " model"}, {m.res, m.ovf, m.unf, m.nan, m.lat}, {want, wflags, 8'(wlat)});
    wait_ready(name);
    op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int j = 1; j <= 60; j++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = j;
        break;
      end
    end
    check({name, " latency"}, lat, wlat);
    check({name, " out"}, {result, flag_ovf, flag_unf, flag_nan}, {want, wflags});
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; op_sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset state", {out_valid, in_ready, result, flag_ovf, flag_unf, flag_nan},
          {1'b0, 1'b1, 32'h0, 3'b000});
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_1_1",   32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 3);
    run_op("sub_k1",    32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 3'b000, 4);
    run_op("far_shift", 32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 3'b000, 3);
    run_op("cancel",    32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 3'b000, 3);
    run_op("overflow",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b100, 3);
    run_op("ulp",       32'h3F800000, 32'h34000000, 1'b0, 32'h3F800001, 3'b000, 3);
    run_op("k24",       32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 3'b000, 27);
    run_op("negative",  32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 3'b000, 4);
    run_op("underflow", 32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 3'b010, 4);
    run_op("zero_op",   32'h00000000, 32'h40400000, 1'b0, 32'h40400000, 3'b000, 3);

    out_ready = 1'b0;
    run_op("nan", 32'h7F800000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b001, 2);
    for (int j = 0; j < 5; j++) begin
      op_a = 32'h40000000; op_b = 32'h40000000; op_sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      check("nan hold", {out_valid, in_ready, result, flag_nan}, {1'b1, 1'b0, 32'h7FC00000, 1'b1});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("nan release", {out_valid, in_ready}, 2'b01);

    wait_ready("reset_norm");
    op_a = 32'h3FC00000; op_b = 32'h3F800000; op_sub = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("reset in norm", {out_valid, in_ready, result, flag_ovf, flag_unf, flag_nan},
          {1'b0, 1'b1, 32'h0, 3'b000});
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      check("no stale valid", {out_valid, in_ready}, 2'b01);
    end
    run_op("add_2_2", 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 3'b000, 3);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "time limit");
  end

endmodule
